uart_tx: RTL



---
 rtl/uart_tx_pkg.sv | 40 ++++
 rtl/uart_tx_rise_detect.sv | 32 +++
 rtl/uart_tx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module : uart_tx_pkg
// Brief  : Shared UART definitions: FSM state encodings, parity mode codes
//          and the parity helper. A future uart_rx will import the same
//          package.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  // Frame sequencer states, 3-bit encoding shared with the receiver.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAR   = 3'd4,
    ST_STOP  = 3'd5
  } uart_state_e;

  // Parity mode codes used by the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bit counter width: enough for the longest payload (8 bits -> index 7).
  localparam int CNT_W = 3;

  // Parity over a zero-extended payload; the padding zeros do not disturb
  // the XOR, so one helper serves every DATA_BITS value.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic x;
    x = ^data;
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_rise_detect.sv
// ============================================================================
// Module : uart_tx_rise_detect
// Brief  : One-clock strobe on each rising edge of a level input that is
//          already synchronous to clk. The history register resets high so
//          an input that is high while reset releases yields no strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic pulse_o
);

  logic prev_q;

  // Remember the previous level of the input every clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= in_i;
    end
  end

  assign pulse_o = in_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module : uart_tx
// Brief  : Byte-serial UART transmitter. Bit periods are paced by rising
//          edges of baud_tick (the clock_divider output); bytes arrive over
//          a valid/ready handshake and tx drives the pad directly.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);

  import uart_tx_pkg::*;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // --------------------------------------------------------------------------
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end

  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in the range 5..8");
  end

  // Last index of the payload and of the stop-bit run, in counter width.
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  // --------------------------------------------------------------------------
  // Bit-period strobe from the divided clock
  // --------------------------------------------------------------------------
  logic baud_en;

  uart_tx_rise_detect u_tick_edge (
    .clk     (clk),
    .rst     (rst),
    .in_i    (baud_tick),
    .pulse_o (baud_en)
  );

  // --------------------------------------------------------------------------
  // Frame sequencer state
  // --------------------------------------------------------------------------
  uart_state_e            state_q,    state_d;
  logic                   tx_q,       tx_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q,     busy_d;
  logic [DATA_BITS-1:0]   shift_q,    shift_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic                   par_q,      par_d;

  // State register; reset aborts any frame in flight and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
    end
  end

  // Next-state logic: tx only moves on baud_en, so every bit, including the
  // start bit, is a whole bit period wide.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    par_d      = par_q;

    case (state_q)
      ST_IDLE: begin
        // A baud_en landing in the accept cycle is deliberately ignored;
        // SYNC then waits for the next edge to start a full-width start bit.
        if (in_valid && in_ready_q) begin
          shift_d    = in_data;
          par_d      = parity_bit(8'(in_data), PARITY);
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (baud_en) begin
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (baud_en) begin
          tx_d    = shift_q[0];
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (baud_en) begin
          if (cnt_q < LAST_DATA) begin
            // LSB first: the bit going out next is the one above bit 0.
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (PARITY != PAR_NONE) begin
            tx_d    = par_q;
            state_d = ST_PAR;
          end else begin
            tx_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_STOP;
          end
        end
      end

      ST_PAR: begin
        if (baud_en) begin
          tx_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (baud_en) begin
          if (cnt_q < LAST_STOP) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            // Ready rises one clock after the final stop edge, so a byte
            // already waiting is taken on the very next clock.
            busy_d     = 1'b0;
            in_ready_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle line.
        tx_d       = 1'b1;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        cnt_d      = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  assign tx       = tx_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire
